// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap sequencer: CSR addresses,
// mcause codes, the sequencer state type and the mip bit layout.
package csr_pkg;

  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MIE    = 12'h304;
  localparam logic [11:0] CSR_MIP    = 12'h344;

  localparam logic [3:0] CODE_MEI     = 4'd11;
  localparam logic [3:0] CODE_MSI     = 4'd3;
  localparam logic [3:0] CODE_MTI     = 4'd7;
  localparam logic [3:0] CODE_ILLEGAL = 4'd2;
  localparam logic [3:0] CODE_ECALL_M = 4'd11;

  // Only MEIE/MTIE/MSIE exist in mie; everything else reads as zero.
  localparam logic [31:0] MIE_WARL_MASK = 32'h0000_0888;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ENTRY  = 2'd1,
    ST_EXIT   = 2'd2,
    ST_SETTLE = 2'd3
  } trap_state_e;

  function automatic logic [31:0] build_mip(input logic ext, input logic tmr, input logic sw);
    return {20'b0, ext, 3'b0, tmr, 3'b0, sw, 3'b0};
  endfunction

endpackage

// File: rtl/irq_prio.sv
// Fixed-priority encoder for the enabled machine interrupts.
// External beats software, software beats timer.
module irq_prio
  import csr_pkg::*;
(
  input  logic       i_mei,
  input  logic       i_msi,
  input  logic       i_mti,
  output logic       o_valid,
  output logic [3:0] o_code
);

  always_comb begin
    o_valid = 1'b1;
    o_code  = 4'd0;
    if (i_mei) begin
      o_code = CODE_MEI;
    end else if (i_msi) begin
      o_code = CODE_MSI;
    end else if (i_mti) begin
      o_code = CODE_MTI;
    end else begin
      o_valid = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap/interrupt sequencer: owns mtvec/mepc/mcause/mie, exposes mip,
// pulses the mstatus MIE stack and redirects fetch on trap entry and MRET.
module trap_ctrl
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
)
(
  input  logic        clock,
  input  logic        rst_n_in,
  input  logic        mie_in,
  input  logic [11:0] csr_addr_in,
  input  logic        wr_en_in,
  input  logic [31:0] csr_data_in,
  input  logic        ext_irq_in,
  input  logic        sw_irq_in,
  input  logic        timer_irq_in,
  input  logic        exc_valid_in,
  input  logic [3:0]  exc_cause_in,
  input  logic        mret_in,
  input  logic [31:0] pc_in,
  output logic        mie_clear_out,
  output logic        mie_set_out,
  output logic        redirect_out,
  output logic [31:0] target_pc_out,
  output logic [31:0] csr_rd_data_out,
  output logic        busy_out
);

  trap_state_e r_state;
  trap_state_e w_state_next;

  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mie;
  logic [31:0] r_target;

  logic [31:0] w_mip;
  logic [31:0] w_base;
  logic [31:0] w_trap_target;
  logic [31:0] w_trap_cause;
  logic        w_irq_valid;
  logic [3:0]  w_irq_code;
  logic        w_irq;
  logic        w_idle;
  logic        w_take_exc;
  logic        w_take_irq;
  logic        w_take_trap;
  logic        w_take_mret;

  assign w_mip = build_mip(ext_irq_in, timer_irq_in, sw_irq_in);

  irq_prio u_irq_prio (
    .i_mei   (ext_irq_in   & r_mie[11]),
    .i_msi   (sw_irq_in    & r_mie[3]),
    .i_mti   (timer_irq_in & r_mie[7]),
    .o_valid (w_irq_valid),
    .o_code  (w_irq_code)
  );

  assign w_irq  = mie_in & w_irq_valid;
  assign w_idle = (r_state == ST_IDLE);

  // Exceptions ignore mie_in and outrank interrupts; MRET only wins when nothing else is pending.
  assign w_take_exc  = w_idle & exc_valid_in;
  assign w_take_irq  = w_idle & ~exc_valid_in & w_irq;
  assign w_take_trap = w_take_exc | w_take_irq;
  assign w_take_mret = w_idle & mret_in & ~exc_valid_in & ~w_irq;

  assign w_base        = {r_mtvec[31:2], 2'b00};
  assign w_trap_target = (r_mtvec[0] && w_take_irq)
                         ? (w_base + {26'b0, w_irq_code, 2'b00})
                         : w_base;
  assign w_trap_cause  = w_take_exc ? {28'b0, exc_cause_in}
                                    : {1'b1, 27'b0, w_irq_code};

  always_ff @(posedge clock or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    mie_clear_out = 1'b0;
    mie_set_out   = 1'b0;
    redirect_out  = 1'b0;
    busy_out      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_take_trap) begin
          w_state_next = ST_ENTRY;
        end else if (w_take_mret) begin
          w_state_next = ST_EXIT;
        end
      end
      ST_ENTRY: begin
        mie_clear_out = 1'b1;
        redirect_out  = 1'b1;
        busy_out      = 1'b1;
        w_state_next  = ST_SETTLE;
      end
      ST_EXIT: begin
        mie_set_out  = 1'b1;
        redirect_out = 1'b1;
        busy_out     = 1'b1;
        w_state_next = ST_SETTLE;
      end
      // One quiet cycle so the core's updated mstatus.MIE is seen before new events.
      ST_SETTLE: begin
        busy_out     = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Trap capture is placed after the CSR write so it overrides mepc/mcause on the same edge.
  always_ff @(posedge clock or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_mtvec  <= {MTVEC_RESET[31:2], 1'b0, MTVEC_RESET[0]};
      r_mepc   <= 32'h0;
      r_mcause <= 32'h0;
      r_mie    <= 32'h0;
      r_target <= 32'h0;
    end else begin
      if (wr_en_in) begin
        case (csr_addr_in)
          CSR_MTVEC:  r_mtvec  <= {csr_data_in[31:2], 1'b0, csr_data_in[0]};
          CSR_MEPC:   r_mepc   <= {csr_data_in[31:2], 2'b00};
          CSR_MCAUSE: r_mcause <= csr_data_in;
          CSR_MIE:    r_mie    <= csr_data_in & MIE_WARL_MASK;
          default: ;
        endcase
      end
      if (w_take_trap) begin
        r_mepc   <= {pc_in[31:2], 2'b00};
        r_mcause <= w_trap_cause;
        r_target <= w_trap_target;
      end else if (w_take_mret) begin
        r_target <= r_mepc;
      end
    end
  end

  assign target_pc_out = r_target;

  always_comb begin
    csr_rd_data_out = 32'h0;
    case (csr_addr_in)
      CSR_MTVEC:  csr_rd_data_out = r_mtvec;
      CSR_MEPC:   csr_rd_data_out = r_mepc;
      CSR_MCAUSE: csr_rd_data_out = r_mcause;
      CSR_MIE:    csr_rd_data_out = r_mie;
      CSR_MIP:    csr_rd_data_out = w_mip;
      default:    csr_rd_data_out = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus a randomized run
// compared against a simple architectural model of the CSRs and trap rules.
module tb_trap_ctrl;
  import csr_pkg::*;

  localparam logic [31:0] RST_VEC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        rst_n_in;
  logic        mie_in;
  logic [11:0] csr_addr_in;
  logic        wr_en_in;
  logic [31:0] csr_data_in;
  logic        ext_irq_in, sw_irq_in, timer_irq_in;
  logic        exc_valid_in;
  logic [3:0]  exc_cause_in;
  logic        mret_in;
  logic [31:0] pc_in;
  logic        mie_clear_out, mie_set_out, redirect_out, busy_out;
  logic [31:0] target_pc_out, csr_rd_data_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mie, m_target;

  trap_ctrl #(.MTVEC_RESET(RST_VEC)) dut (
    .clock(clock), .rst_n_in(rst_n_in), .mie_in(mie_in),
    .csr_addr_in(csr_addr_in), .wr_en_in(wr_en_in), .csr_data_in(csr_data_in),
    .ext_irq_in(ext_irq_in), .sw_irq_in(sw_irq_in), .timer_irq_in(timer_irq_in),
    .exc_valid_in(exc_valid_in), .exc_cause_in(exc_cause_in), .mret_in(mret_in),
    .pc_in(pc_in), .mie_clear_out(mie_clear_out), .mie_set_out(mie_set_out),
    .redirect_out(redirect_out), .target_pc_out(target_pc_out),
    .csr_rd_data_out(csr_rd_data_out), .busy_out(busy_out)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet_inputs();
    mie_in = 0; wr_en_in = 0; csr_addr_in = 12'h0; csr_data_in = 0;
    ext_irq_in = 0; sw_irq_in = 0; timer_irq_in = 0;
    exc_valid_in = 0; exc_cause_in = 0; mret_in = 0; pc_in = 0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csr_addr_in = a;
    #1;
    d = csr_rd_data_out;
  endtask

  function automatic void model_reset();
    m_mtvec = RST_VEC & ~32'h2; m_mepc = 0; m_mcause = 0; m_mie = 0; m_target = 0;
  endfunction

  function automatic void model_write(input logic [11:0] a, input logic [31:0] d, input bit trap);
    if (a == CSR_MTVEC) m_mtvec = d & ~32'h2;
    else if (a == CSR_MIE) m_mie = d & 32'h888;
    else if (a == CSR_MEPC && !trap) m_mepc = d & ~32'h3;
    else if (a == CSR_MCAUSE && !trap) m_mcause = d;
  endfunction

  // Highest-priority enabled interrupt code, or -1 when none is taken.
  function automatic int model_irq(input bit gmie, input bit ext, input bit tmr, input bit sw);
    logic [31:0] pend;
    pend = ((ext ? 32'd1 : 32'd0) << 11 | (tmr ? 32'd1 : 32'd0) << 7 | (sw ? 32'd1 : 32'd0) << 3) & m_mie;
    if (!gmie || pend == 0) return -1;
    if (pend[11]) return 11;
    if (pend[3]) return 3;
    return 7;
  endfunction

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    wr_en_in = 1; csr_addr_in = a; csr_data_in = d;
    step();
    wr_en_in = 0;
    model_write(a, d, 1'b0);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    quiet_inputs();
    rst_n_in = 0;
    repeat (3) step();
    rst_n_in = 1;
    model_reset();
    step();
    rd(CSR_MTVEC, d);  checks++; if (d !== RST_VEC) begin errors++; $display("FAIL reset_mtvec: got %h expected %h", d, RST_VEC); end
    rd(CSR_MEPC, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mepc: got %h expected 0", d); end
    rd(CSR_MCAUSE, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mcause: got %h expected 0", d); end
    rd(CSR_MIE, d);    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mie: got %h expected 0", d); end
    checks++; if ({mie_clear_out, mie_set_out, redirect_out, busy_out} !== 4'b0 || target_pc_out !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: got %b/%h expected 0000/0", {mie_clear_out, mie_set_out, redirect_out, busy_out}, target_pc_out);
    end
    ext_irq_in = 1; timer_irq_in = 1;
    rd(CSR_MIP, d);    checks++; if (d !== 32'h0000_0880) begin errors++; $display("FAIL reset_mip: got %h expected 00000880", d); end
    csr_write(CSR_MIP, 32'hFFFF_FFFF);
    rd(CSR_MIP, d);    checks++; if (d !== 32'h0000_0880) begin errors++; $display("FAIL mip_readonly: got %h expected 00000880", d); end
    ext_irq_in = 0; timer_irq_in = 0;
    $display("test_reset done");
  endtask

  task automatic settle_and_check(input string tag);
    step();
    checks++; if (busy_out !== 1'b1 || redirect_out !== 1'b0 || mie_clear_out !== 1'b0 || mie_set_out !== 1'b0) begin
      errors++; $display("FAIL %s_settle: got busy=%b redir=%b clr=%b set=%b expected 1 0 0 0", tag, busy_out, redirect_out, mie_clear_out, mie_set_out);
    end
    mie_in = 0;
    step();
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL %s_idle_busy: got %b expected 0", tag, busy_out); end
  endtask

  task automatic test_exception();
    logic [31:0] d;
    csr_write(CSR_MTVEC, 32'h0000_0100);
    exc_valid_in = 1; exc_cause_in = CODE_ILLEGAL; pc_in = 32'h0000_0040;
    step();
    exc_valid_in = 0;
    checks++; if (mie_clear_out !== 1'b1 || redirect_out !== 1'b1 || busy_out !== 1'b1 || mie_set_out !== 1'b0) begin
      errors++; $display("FAIL exc_pulses: got clr=%b redir=%b busy=%b set=%b expected 1 1 1 0", mie_clear_out, redirect_out, busy_out, mie_set_out);
    end
    checks++; if (target_pc_out !== 32'h100) begin errors++; $display("FAIL exc_target: got %h expected 00000100", target_pc_out); end
    rd(CSR_MEPC, d);   checks++; if (d !== 32'h40) begin errors++; $display("FAIL exc_mepc: got %h expected 00000040", d); end
    rd(CSR_MCAUSE, d); checks++; if (d !== 32'h2) begin errors++; $display("FAIL exc_mcause: got %h expected 00000002", d); end
    m_mepc = 32'h40; m_mcause = 32'h2; m_target = 32'h100;
    settle_and_check("exc");
    $display("test_exception done");
  endtask

  task automatic test_irq_vectored();
    logic [31:0] d;
    csr_write(CSR_MTVEC, 32'h0000_0101);
    csr_write(CSR_MIE, 32'h0000_0880);
    mie_in = 1; ext_irq_in = 1; timer_irq_in = 1; pc_in = 32'h0000_0200;
    step();
    checks++; if (target_pc_out !== 32'h12C || redirect_out !== 1'b1 || mie_clear_out !== 1'b1) begin
      errors++; $display("FAIL irq_entry: got target=%h redir=%b clr=%b expected 0000012c 1 1", target_pc_out, redirect_out, mie_clear_out);
    end
    rd(CSR_MCAUSE, d); checks++; if (d !== 32'h8000_000B) begin errors++; $display("FAIL irq_mcause: got %h expected 8000000b", d); end
    rd(CSR_MEPC, d);   checks++; if (d !== 32'h200) begin errors++; $display("FAIL irq_mepc: got %h expected 00000200", d); end
    m_mepc = 32'h200; m_mcause = 32'h8000_000B; m_target = 32'h12C;
    // lines and mie_in stay high into SETTLE: no second trap may start there
    settle_and_check("irq");
    step();
    checks++; if (redirect_out !== 1'b0 || busy_out !== 1'b0) begin
      errors++; $display("FAIL irq_masked_after: got redir=%b busy=%b expected 0 0", redirect_out, busy_out);
    end
    ext_irq_in = 0; timer_irq_in = 0;
    $display("test_irq_vectored done");
  endtask

  task automatic test_irq_masked();
    logic [31:0] d;
    csr_write(CSR_MIE, 32'h0000_0080);
    timer_irq_in = 1; mie_in = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (redirect_out !== 1'b0 || busy_out !== 1'b0 || mie_clear_out !== 1'b0) begin
        errors++; $display("FAIL masked_cycle%0d: got redir=%b busy=%b clr=%b expected 0 0 0", i, redirect_out, busy_out, mie_clear_out);
      end
    end
    rd(CSR_MCAUSE, d); checks++; if (d !== m_mcause) begin errors++; $display("FAIL masked_mcause: got %h expected %h", d, m_mcause); end
    timer_irq_in = 0;
    $display("test_irq_masked done");
  endtask

  task automatic test_mret();
    csr_write(CSR_MEPC, 32'h0000_0044);
    mret_in = 1;
    step();
    mret_in = 0;
    checks++; if (mie_set_out !== 1'b1 || redirect_out !== 1'b1 || busy_out !== 1'b1 || mie_clear_out !== 1'b0) begin
      errors++; $display("FAIL mret_pulses: got set=%b redir=%b busy=%b clr=%b expected 1 1 1 0", mie_set_out, redirect_out, busy_out, mie_clear_out);
    end
    checks++; if (target_pc_out !== 32'h44) begin errors++; $display("FAIL mret_target: got %h expected 00000044", target_pc_out); end
    m_target = 32'h44;
    settle_and_check("mret");
    $display("test_mret done");
  endtask

  task automatic test_exc_with_mret();
    exc_valid_in = 1; mret_in = 1; exc_cause_in = CODE_ECALL_M; pc_in = 32'h0000_0303;
    step();
    exc_valid_in = 0; mret_in = 0;
    checks++; if (mie_clear_out !== 1'b1 || mie_set_out !== 1'b0) begin
      errors++; $display("FAIL exc_mret_prio: got clr=%b set=%b expected 1 0", mie_clear_out, mie_set_out);
    end
    checks++; if (target_pc_out !== (m_mtvec & ~32'h3)) begin
      errors++; $display("FAIL exc_mret_target: got %h expected %h", target_pc_out, m_mtvec & ~32'h3);
    end
    m_mepc = 32'h300; m_mcause = {28'b0, CODE_ECALL_M}; m_target = m_mtvec & ~32'h3;
    settle_and_check("exc_mret");
    $display("test_exc_with_mret done");
  endtask

  task automatic test_csr_collision();
    logic [31:0] d;
    wr_en_in = 1; csr_addr_in = CSR_MEPC; csr_data_in = 32'h0000_0999;
    exc_valid_in = 1; exc_cause_in = CODE_ILLEGAL; pc_in = 32'h0000_0080;
    step();
    wr_en_in = 0; exc_valid_in = 0;
    rd(CSR_MEPC, d); checks++; if (d !== 32'h80) begin errors++; $display("FAIL collision_mepc: got %h expected 00000080", d); end
    m_mepc = 32'h80; m_mcause = 32'h2; m_target = m_mtvec & ~32'h3;
    settle_and_check("collision");
    $display("test_csr_collision done");
  endtask

  task automatic test_reset_mid_entry();
    logic [31:0] d;
    exc_valid_in = 1; exc_cause_in = CODE_ILLEGAL; pc_in = 32'h0000_0500;
    step();
    exc_valid_in = 0;
    checks++; if (mie_clear_out !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got clr=%b expected 1", mie_clear_out); end
    rst_n_in = 0;
    #1;
    checks++; if ({mie_clear_out, mie_set_out, redirect_out, busy_out} !== 4'b0 || target_pc_out !== 32'h0) begin
      errors++; $display("FAIL rst_mid_outputs: got %b/%h expected 0000/0", {mie_clear_out, mie_set_out, redirect_out, busy_out}, target_pc_out);
    end
    rd(CSR_MEPC, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_mid_mepc: got %h expected 0", d); end
    #1;
    rst_n_in = 1;
    model_reset();
    step();
    checks++; if (busy_out !== 1'b0 || redirect_out !== 1'b0) begin
      errors++; $display("FAIL rst_mid_after: got busy=%b redir=%b expected 0 0", busy_out, redirect_out);
    end
    $display("test_reset_mid_entry done");
  endtask

  task automatic test_random();
    logic [11:0] addrs [5];
    logic [31:0] d, exp_target;
    int irqc;
    bit trap, do_mret;
    addrs[0] = CSR_MTVEC; addrs[1] = CSR_MEPC; addrs[2] = CSR_MCAUSE; addrs[3] = CSR_MIE; addrs[4] = CSR_MIP;
    csr_write(CSR_MIE, 32'h0000_0888);
    for (int it = 0; it < 200; it++) begin
      mie_in       = 1'($urandom_range(0, 1));
      ext_irq_in   = ($urandom_range(0, 3) == 0);
      sw_irq_in    = ($urandom_range(0, 3) == 0);
      timer_irq_in = ($urandom_range(0, 3) == 0);
      exc_valid_in = ($urandom_range(0, 4) == 0);
      mret_in      = ($urandom_range(0, 3) == 0);
      exc_cause_in = 4'($urandom_range(0, 15));
      pc_in        = $urandom;
      wr_en_in     = ($urandom_range(0, 2) == 0);
      csr_addr_in  = addrs[$urandom_range(0, 4)];
      csr_data_in  = $urandom;

      irqc    = model_irq(mie_in, ext_irq_in, timer_irq_in, sw_irq_in);
      trap    = exc_valid_in || (irqc >= 0);
      do_mret = !trap && mret_in;
      if (exc_valid_in) exp_target = m_mtvec & ~32'h3;
      else if (irqc >= 0) exp_target = (m_mtvec[0] ? (m_mtvec & ~32'h3) + 32'(4 * irqc) : (m_mtvec & ~32'h3));
      else if (do_mret) exp_target = m_mepc;
      else exp_target = m_target;

      step();
      if (wr_en_in) model_write(csr_addr_in, csr_data_in, trap);
      if (trap) begin
        m_mepc   = pc_in & ~32'h3;
        m_mcause = exc_valid_in ? {28'b0, exc_cause_in} : (32'h8000_0000 | 32'(irqc));
      end
      m_target = exp_target;
      quiet_inputs();

      checks++;
      if (mie_clear_out !== trap || mie_set_out !== do_mret || redirect_out !== (trap || do_mret) ||
          busy_out !== (trap || do_mret) || target_pc_out !== exp_target) begin
        errors++;
        $display("FAIL rand%0d_event: got clr=%b set=%b redir=%b busy=%b tgt=%h expected %b %b %b %b %h",
                 it, mie_clear_out, mie_set_out, redirect_out, busy_out, target_pc_out,
                 trap, do_mret, trap || do_mret, trap || do_mret, exp_target);
      end
      rd(CSR_MTVEC, d);  checks++; if (d !== m_mtvec)  begin errors++; $display("FAIL rand%0d_mtvec: got %h expected %h", it, d, m_mtvec); end
      rd(CSR_MEPC, d);   checks++; if (d !== m_mepc)   begin errors++; $display("FAIL rand%0d_mepc: got %h expected %h", it, d, m_mepc); end
      rd(CSR_MCAUSE, d); checks++; if (d !== m_mcause) begin errors++; $display("FAIL rand%0d_mcause: got %h expected %h", it, d, m_mcause); end
      rd(CSR_MIE, d);    checks++; if (d !== m_mie)    begin errors++; $display("FAIL rand%0d_mie: got %h expected %h", it, d, m_mie); end
      if (trap || do_mret) settle_and_check($sformatf("rand%0d", it));
      $display("rand %0d trap=%0b mret=%0b target=%h", it, trap, do_mret, exp_target);
    end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_irq_vectored();
    test_irq_masked();
    test_mret();
    test_exc_with_mret();
    test_csr_collision();
    test_reset_mid_entry();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
